debug_capture_ctrl: RTL and testbench

// - Sequences a shared debug-capture path. Selects one of NSRC 53-bit debug buses, arms a

---
 rtl/debug_capture_ctrl_if.sv | 12 +
 rtl/debug_capture_ctrl.sv | 172 +++++++++++++++++
 tb/tb_debug_capture_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_capture_ctrl_if.sv
// Readout stream between debug_capture_ctrl (master) and the PC/PCIe readout sink (slave).
interface debug_capture_ctrl_if #(
  parameter int W = 53
);
  logic         rd_valid_o;
  logic [W-1:0] rd_data_o;
  logic         rd_last_o;
  logic         rd_ready_i;

  modport master (output rd_valid_o, rd_data_o, rd_last_o, input rd_ready_i);
  modport slave  (input rd_valid_o, rd_data_o, rd_last_o, output rd_ready_i);
endinterface

// File: rtl/debug_capture_ctrl.sv
// Debug capture sequencer: source mux, pattern trigger, DEPTH-word capture RAM and streamed readout.
// Optional feature macro DBG_EXT_TRIG_EN adds ext_trig_i as an extra trigger source.
module debug_capture_ctrl #(
  parameter int NSRC  = 7,
  parameter int DEPTH = 256,
  parameter int GUARD = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NSRC*53-1:0]   dbg_i,
  input  logic [2:0]           src_sel_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic [52:0]          trig_mask_i,
  input  logic [52:0]          trig_value_i,
`ifdef DBG_EXT_TRIG_EN
  input  logic                 ext_trig_i,
`endif
  debug_capture_ctrl_if.master rd,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           state_o
);
  localparam int W  = 53;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(GUARD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t        state;
  logic [2:0]    sel_q;
  logic [W-1:0]  mux_q, mux_d;
  logic [CW-1:0] cnt;
  logic          arm_pend;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_valid_q, rd_last_q, done_q;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  ram_q;

  logic          trig, sel_chg, rd_hs, wr_last, mem_we, ram_re;
  logic [AW-1:0] mem_wa, rd_addr;

  // Out-of-range selects fall through to zero.
  always_comb begin
    mux_d = '0;
    for (int k = 0; k < NSRC; k++)
      if (sel_q == 3'(k)) mux_d = dbg_i[k*W +: W];
  end

`ifdef DBG_EXT_TRIG_EN
  assign trig = (((mux_q ^ trig_value_i) & trig_mask_i) == '0) | ext_trig_i;
`else
  assign trig = (((mux_q ^ trig_value_i) & trig_mask_i) == '0);
`endif

  // A select change is held off during readout so a capture is never read from two sources.
  assign sel_chg = (src_sel_i != sel_q) && (state != S_READOUT);
  assign rd_hs   = rd_valid_q & rd.rd_ready_i;
  assign wr_last = (wr_ptr == AW'(DEPTH-1));

  assign mem_we  = rst_n_i && !abort_i && !sel_chg &&
                   ((state == S_ARMED && trig) || state == S_CAPTURE);
  assign mem_wa  = (state == S_CAPTURE) ? wr_ptr : '0;

  // Prefetch: word 0 is fetched as capture ends, word n+1 on the handshake of word n.
  assign ram_re  = rst_n_i && !abort_i &&
                   ((state == S_CAPTURE && !sel_chg && wr_last) ||
                    (state == S_READOUT && rd_hs && !rd_last_q));
  assign rd_addr = (state == S_READOUT) ? rd_ptr + AW'(1) : '0;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_wa] <= mux_q;
    if (ram_re) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      sel_q      <= '0;
      mux_q      <= '0;
      cnt        <= '0;
      arm_pend   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mux_q <= mux_d;
      if (abort_i) begin
        state      <= S_IDLE;
        arm_pend   <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
        done_q     <= 1'b0;
      end else if (sel_chg) begin
        sel_q  <= src_sel_i;
        state  <= S_SETTLE;
        cnt    <= CW'(GUARD-1);
        wr_ptr <= '0;
        done_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_i) begin
              state  <= S_ARMED;
              done_q <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (cnt == '0) begin
              state    <= (arm_pend || arm_i) ? S_ARMED : S_IDLE;
              arm_pend <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
              if (arm_i) arm_pend <= 1'b1;
            end
          end
          S_ARMED: begin
            if (trig) begin
              wr_ptr <= AW'(1);
              state  <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (wr_last) begin
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              rd_valid_q <= 1'b1;
              rd_last_q  <= 1'b0;
              state      <= S_READOUT;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
          S_READOUT: begin
            if (rd_hs) begin
              if (rd_last_q) begin
                rd_ptr     <= '0;
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
                done_q     <= 1'b1;
                state      <= S_IDLE;
              end else begin
                rd_ptr    <= rd_ptr + AW'(1);
                rd_last_q <= (rd_ptr + AW'(1) == AW'(DEPTH-1));
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd.rd_valid_o = rd_valid_q;
  assign rd.rd_last_o  = rd_last_q;
  // RAM output register has no reset; gate it so the bus reads zero when idle.
  assign rd.rd_data_o  = ram_q & {W{rd_valid_q}};
  assign busy_o        = (state != S_IDLE);
  assign done_o        = done_q;
  assign state_o       = state;
endmodule

// File: tb/tb_debug_capture_ctrl.sv
// Scoreboard bench for debug_capture_ctrl: planned debug data, expected readout queue, stream monitor.
module tb_debug_capture_ctrl;
  localparam int NSRC  = 7;
  localparam int DEPTH = 256;
  localparam int GUARD = 4;

  typedef struct packed {
    logic [52:0] d;
    logic        last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NSRC*53-1:0] dbg_i;
  logic [2:0]         src_sel_i;
  logic               arm_i, abort_i;
  logic [52:0]        trig_mask_i, trig_value_i;
  logic               busy_o, done_o;
  logic [2:0]         state_o;
`ifdef DBG_EXT_TRIG_EN
  logic               ext_trig_i = 1'b0;
`endif

  debug_capture_ctrl_if rd_if ();

  debug_capture_ctrl #(.NSRC(NSRC), .DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dbg_i        (dbg_i),
    .src_sel_i    (src_sel_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
`ifdef DBG_EXT_TRIG_EN
    .ext_trig_i   (ext_trig_i),
`endif
    .rd           (rd_if),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [52:0] plan[$];
  int          plan_sel   = 0;
  int          ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [52:0] rand53();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[52:0];
  endfunction

  function automatic logic [NSRC*53-1:0] mk_bus(input int sel, input logic [52:0] v);
    logic [NSRC*53-1:0] b;
    for (int k = 0; k < NSRC; k++) b[k*53 +: 53] = (k == sel) ? v : rand53();
    return b;
  endfunction

  function automatic bit hit(input logic [52:0] v, input logic [52:0] m, input logic [52:0] val);
    return ((v ^ val) & m) == '0;
  endfunction

  // One clock: new data/ready just after the rising edge, return at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (plan.size() > 0) dbg_i = mk_bus(plan_sel, plan.pop_front());
    else                 dbg_i = mk_bus(plan_sel, rand53());
    case (ready_mode)
      0:       rd_if.rd_ready_i = 1'b1;
      1:       rd_if.rd_ready_i = ~rd_if.rd_ready_i;
      default: rd_if.rd_ready_i = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
  endtask

  task automatic settle_chk();
    cyc();
    repeat (GUARD) begin
      chk("settle_state", state_o, 3'd1);
      cyc();
    end
    chk("settle_exit", state_o, 3'd0);
  endtask

  // Capture = DEPTH consecutive source samples starting at the first one matching the trigger;
  // the sample seen alongside arm_i is the first candidate.
  task automatic run_capture(input int sel, input logic [52:0] m, input logic [52:0] val,
                             input bit ramp, input bit force_hit, input bit push, input bit chk_arm);
    logic [52:0] p[$];
    exp_t        e;
    int          t;
    trig_mask_i  = m;
    trig_value_i = val;
    for (int i = 0; i < 64 + DEPTH; i++) p.push_back(ramp ? 53'(i) : rand53());
    if (force_hit) p[60] = val;
    t = -1;
    for (int i = 0; i < 64; i++) if (t < 0 && hit(p[i], m, val)) t = i;
    if (push && t >= 0)
      for (int k = 0; k < DEPTH; k++) begin
        e.d = p[t+k];
        e.last = (k == DEPTH-1);
        exp_q.push_back(e);
      end
    plan_sel = sel;
    dbg_i    = mk_bus(sel, p.pop_front());
    plan     = p;
    arm_i    = 1'b1;
    cyc();
    arm_i    = 1'b0;
    if (chk_arm) begin
      chk("armed_state", state_o, 3'd2);
      if (t == 0) begin
        cyc();
        chk("capture_state", state_o, 3'd3);
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 3000) begin
      cyc();
      n++;
    end
    chk("done_seen", done_o, 1);
    chk("done_idle", state_o, 3'd0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (state_o != s && n < 1000) begin
      cyc();
      n++;
    end
    chk("wait_state", state_o, s);
  endtask

  // Stream monitor: pops the scoreboard on each handshake, checks hold during stalls.
  initial begin
    exp_t        e;
    logic        held_v;
    logic [52:0] held_d;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || rd_if.rd_valid_o !== 1'b1) begin
        held_v = 1'b0;
      end else begin
        if (held_v) chk("stall_hold", rd_if.rd_data_o, held_d);
        if (rd_if.rd_ready_i) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", rd_if.rd_data_o, e.d);
            chk("rd_last", rd_if.rd_last_o, e.last);
          end
        end else begin
          held_v = 1'b1;
          held_d = rd_if.rd_data_o;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [52:0] m;
    rst_n = 1'b0; arm_i = 1'b1; abort_i = 1'b0; src_sel_i = 3'd0;
    trig_mask_i = '0; trig_value_i = '0; dbg_i = '0; rd_if.rd_ready_i = 1'b1;

    repeat (3) begin
      cyc();
      chk("rst_state", state_o, 3'd0);
      chk("rst_busy",  busy_o, 0);
      chk("rst_done",  done_o, 0);
      chk("rst_valid", rd_if.rd_valid_o, 0);
      chk("rst_last",  rd_if.rd_last_o, 0);
      chk("rst_data",  rd_if.rd_data_o, 0);
    end
    rst_n = 1'b1; arm_i = 1'b0;

    src_sel_i = 3'd2;
    plan_sel  = 2;
    settle_chk();

    // zero mask: triggers on first ARMED cycle
    ready_mode = 0;
    run_capture(2, '0, rand53(), 0, 0, 1, 1);
    wait_done();

    // ramp with low-bit pattern, sink toggling
    ready_mode = 1;
    run_capture(2, 53'h1F, 53'd5, 1, 0, 1, 1);
    wait_done();

    // sparse random masks, random sink stalls
    ready_mode = 2;
    repeat (3) begin
      m = '0;
      repeat (4) m[$urandom_range(52, 0)] = 1'b1;
      run_capture(2, m, rand53(), 0, 1, 1, 0);
      wait_done();
    end

    // select change mid-capture aborts and settles
    ready_mode = 0;
    run_capture(2, '0, '0, 0, 0, 0, 1);
    repeat (10) cyc();
    chk("midcap_state", state_o, 3'd3);
    src_sel_i = 3'd4;
    settle_chk();
    chk("midcap_done", done_o, 0);
    chk("midcap_valid", rd_if.rd_valid_o, 0);

    // select change during readout is deferred until the last word
    src_sel_i = 3'd2;
    settle_chk();
    run_capture(2, '0, '0, 0, 0, 1, 1);
    wait_state(3'd4);
    src_sel_i = 3'd4;
    wait_done();
    settle_chk();
    chk("defer_done_cleared", done_o, 0);

    // arm during settle is remembered
    trig_mask_i = '0;
    src_sel_i   = 3'd2;
    plan_sel    = 2;
    cyc();
    chk("pend_settle", state_o, 3'd1);
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
    wait_state(3'd2);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("pend_abort", state_o, 3'd0);

    // abort beats arm while ARMED
    run_capture(2, '1, rand53(), 0, 0, 0, 1);
    abort_i = 1'b1; arm_i = 1'b1;
    cyc();
    abort_i = 1'b0; arm_i = 1'b0;
    chk("abort_state", state_o, 3'd0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    repeat (2) cyc();
    chk("abort_stays_idle", state_o, 3'd0);

`ifdef DBG_EXT_TRIG_EN
    run_capture(2, '1, rand53(), 0, 0, 0, 1);
    repeat (3) cyc();
    chk("ext_wait_armed", state_o, 3'd2);
    ext_trig_i = 1'b1;
    cyc();
    ext_trig_i = 1'b0;
    chk("ext_capture", state_o, 3'd3);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("ext_abort", state_o, 3'd0);
`endif

    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
